// File: rtl/bus_xbar_arbiter.sv
// Shared-bus arbiter/decoder: NUM_M masters onto NUM_S slaves, one transaction at a time,
// with decode-error responses and a data-phase watchdog. Define BUS_RR_ARB_EN for round-robin grants.
module bus_xbar_arbiter #(
    parameter int unsigned NUM_M    = 4,
    parameter int unsigned NUM_S    = 8,
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned SEL_BITS = 4,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_M-1:0]          m_req_i,
    input  logic [NUM_M-1:0]          m_we_i,
    input  logic [NUM_M*AW-1:0]       m_addr_i,
    input  logic [NUM_M*DW-1:0]       m_data_i,
    input  logic [NUM_M*(DW/8)-1:0]   m_wem_i,
    output logic [DW-1:0]             m_data_o,
    output logic [NUM_M-1:0]          m_addr_ok_o,
    output logic [NUM_M-1:0]          m_data_ok_o,
    output logic [NUM_M-1:0]          m_err_o,
    output logic [NUM_S-1:0]          s_req_o,
    output logic                      s_we_o,
    output logic [AW-1:0]             s_addr_o,
    output logic [DW-1:0]             s_data_o,
    output logic [DW/8-1:0]           s_wem_o,
    input  logic [NUM_S*DW-1:0]       s_data_i,
    input  logic [NUM_S-1:0]          s_addr_ok_i,
    input  logic [NUM_S-1:0]          s_data_ok_i,
    output logic [NUM_M-1:0]          grant_o,
    output logic                      hold_flag_o
);

    localparam int unsigned MW  = DW / 8;
    localparam int unsigned MIW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int unsigned WDW = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ERR
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_M-1:0]    grant_q, grant_d;
    logic [MIW-1:0]      gidx_q, gidx_d;
    logic [SEL_BITS-1:0] sel_q, sel_d;
    logic [WDW-1:0]      wdog_q, wdog_d;
`ifdef BUS_RR_ARB_EN
    logic [MIW-1:0]      rr_ptr_q, rr_ptr_d;
    logic                hi_vld;
    logic [MIW-1:0]      hi_idx;
`endif

    logic                lo_vld;
    logic [MIW-1:0]      lo_idx;
    logic                win_vld;
    logic [MIW-1:0]      win_idx;
    logic [SEL_BITS-1:0] win_sel;

    logic                g_req;
    logic                g_we;
    logic [AW-1:0]       g_addr;
    logic [DW-1:0]       g_data;
    logic [MW-1:0]       g_wem;

    logic [NUM_S-1:0]    sel_oh;
    logic                sl_addr_ok;
    logic                sl_data_ok;
    logic [DW-1:0]       sl_data;

    // Winner search: lowest requester overall, or lowest at/above rr_ptr with wrap-around
    always_comb begin
        lo_vld = 1'b0;
        lo_idx = '0;
`ifdef BUS_RR_ARB_EN
        hi_vld = 1'b0;
        hi_idx = '0;
`endif
        for (int i = int'(NUM_M) - 1; i >= 0; i--) begin
            if (m_req_i[i]) begin
                lo_vld = 1'b1;
                lo_idx = MIW'(i);
`ifdef BUS_RR_ARB_EN
                if (MIW'(i) >= rr_ptr_q) begin
                    hi_vld = 1'b1;
                    hi_idx = MIW'(i);
                end
`endif
            end
        end
        win_vld = lo_vld;
`ifdef BUS_RR_ARB_EN
        win_idx = hi_vld ? hi_idx : lo_idx;
`else
        win_idx = lo_idx;
`endif
    end

    // Slave select field of the winning master's address
    always_comb begin
        win_sel = '0;
        for (int i = 0; i < int'(NUM_M); i++) begin
            if (win_idx == MIW'(i)) begin
                win_sel = m_addr_i[i*AW + AW - SEL_BITS +: SEL_BITS];
            end
        end
    end

    // Payload of the currently granted master
    always_comb begin
        g_req  = 1'b0;
        g_we   = 1'b0;
        g_addr = '0;
        g_data = '0;
        g_wem  = '0;
        for (int i = 0; i < int'(NUM_M); i++) begin
            if (grant_q[i]) begin
                g_req  = m_req_i[i];
                g_we   = m_we_i[i];
                g_addr = m_addr_i[i*AW +: AW];
                g_data = m_data_i[i*DW +: DW];
                g_wem  = m_wem_i[i*MW +: MW];
            end
        end
    end

    // Response of the selected slave; an unmapped select matches nothing
    always_comb begin
        sel_oh     = '0;
        sl_addr_ok = 1'b0;
        sl_data_ok = 1'b0;
        sl_data    = '0;
        for (int s = 0; s < int'(NUM_S); s++) begin
            if (sel_q == SEL_BITS'(s)) begin
                sel_oh[s]  = 1'b1;
                sl_addr_ok = s_addr_ok_i[s];
                sl_data_ok = s_data_ok_i[s];
                sl_data    = s_data_i[s*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            sel_q    <= '0;
            wdog_q   <= '0;
`ifdef BUS_RR_ARB_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            sel_q    <= sel_d;
            wdog_q   <= wdog_d;
`ifdef BUS_RR_ARB_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    // Next state and handshake responses
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        sel_d       = sel_q;
        wdog_d      = '0;
`ifdef BUS_RR_ARB_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        s_req_o     = '0;
        m_addr_ok_o = '0;
        m_data_ok_o = '0;
        m_err_o     = '0;
        m_data_o    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    grant_d = NUM_M'(1) << win_idx;
                    gidx_d  = win_idx;
                    sel_d   = win_sel;
`ifdef BUS_RR_ARB_EN
                    rr_ptr_d = (32'(win_idx) + 32'd1 == NUM_M) ? '0 : win_idx + MIW'(1);
`endif
                    state_d = (32'(win_sel) < NUM_S) ? ST_ADDR : ST_ERR;
                end
            end

            ST_ADDR: begin
                s_req_o = sel_oh & {NUM_S{g_req}};
                if (!g_req) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if (sl_addr_ok) begin
                    m_addr_ok_o = grant_q;
                    if (sl_data_ok) begin
                        m_data_ok_o = grant_q;
                        m_data_o    = sl_data;
                        state_d     = ST_IDLE;
                        grant_d     = '0;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                // A data_ok in the final watchdog cycle still completes normally
                if (sl_data_ok) begin
                    m_data_ok_o = grant_q;
                    m_data_o    = sl_data;
                    state_d     = ST_IDLE;
                    grant_d     = '0;
                end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                    m_data_ok_o = grant_q;
                    m_err_o     = grant_q;
                    state_d     = ST_IDLE;
                    grant_d     = '0;
                end else begin
                    wdog_d = wdog_q + WDW'(1);
                end
            end

            ST_ERR: begin
                m_addr_ok_o = grant_q;
                m_data_ok_o = grant_q;
                m_err_o     = grant_q;
                state_d     = ST_IDLE;
                grant_d     = '0;
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign s_we_o      = g_we;
    assign s_addr_o    = g_addr;
    assign s_data_o    = g_data;
    assign s_wem_o     = g_wem;
    assign grant_o     = grant_q;
    assign hold_flag_o = (state_q != ST_IDLE) && (32'(gidx_q) >= 32'd2);

endmodule

// File: tb/tb_bus_xbar_arbiter.sv
// Scoreboard bench for bus_xbar_arbiter: expected completions queued at request time,
// popped and compared by a monitor whenever any m_data_ok_o pulses.
module tb_bus_xbar_arbiter;

    localparam int unsigned NUM_M    = 4;
    localparam int unsigned NUM_S    = 8;
    localparam int unsigned AW       = 32;
    localparam int unsigned DW       = 32;
    localparam int unsigned MW       = DW / 8;
    localparam int unsigned SEL_BITS = 4;
    localparam int unsigned TIMEOUT  = 255;

    typedef struct {
        int            m;
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_M-1:0]      m_req;
    logic [NUM_M-1:0]      m_we;
    logic [NUM_M*AW-1:0]   m_addr;
    logic [NUM_M*DW-1:0]   m_data;
    logic [NUM_M*MW-1:0]   m_wem;
    logic [NUM_S*DW-1:0]   s_data;
    logic [NUM_S-1:0]      s_addr_ok;
    logic [NUM_S-1:0]      s_data_ok;

    logic [DW-1:0]         m_data_o;
    logic [NUM_M-1:0]      m_addr_ok_o;
    logic [NUM_M-1:0]      m_data_ok_o;
    logic [NUM_M-1:0]      m_err_o;
    logic [NUM_S-1:0]      s_req_o;
    logic                  s_we_o;
    logic [AW-1:0]         s_addr_o;
    logic [DW-1:0]         s_data_o;
    logic [MW-1:0]         s_wem_o;
    logic [NUM_M-1:0]      grant_o;
    logic                  hold_flag_o;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    bus_xbar_arbiter #(
        .NUM_M(NUM_M), .NUM_S(NUM_S), .AW(AW), .DW(DW),
        .SEL_BITS(SEL_BITS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_data_i(m_data), .m_wem_i(m_wem),
        .m_data_o(m_data_o), .m_addr_ok_o(m_addr_ok_o), .m_data_ok_o(m_data_ok_o), .m_err_o(m_err_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_wem_o(s_wem_o),
        .s_data_i(s_data), .s_addr_ok_i(s_addr_ok), .s_data_ok_i(s_data_ok),
        .grant_o(grant_o), .hold_flag_o(hold_flag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1);
    end

    // Scoreboard consumer: every completion pulse must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        logic [NUM_M-1:0] want_oh;
        #2;
        if (m_data_ok_o !== '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: data_ok %b err %b data %h, none expected", m_data_ok_o, m_err_o, m_data_o);
            end else begin
                e = exp_q.pop_front();
                want_oh = '0;
                want_oh[e.m] = 1'b1;
                if (m_data_ok_o !== want_oh || m_err_o !== (e.err ? want_oh : '0) || m_data_o !== e.data) begin
                    errors++;
                    $display("FAIL sb_resp: data_ok %b err %b data %h, want data_ok %b err %0b data %h",
                             m_data_ok_o, m_err_o, m_data_o, want_oh, e.err, e.data);
                end
            end
        end
    end

    task automatic clear_all();
        m_req = '0; m_we = '0; s_addr_ok = '0; s_data_ok = '0;
    endtask

    task automatic set_master(input int m, input logic [AW-1:0] a, input logic we,
                              input logic [DW-1:0] d, input logic [MW-1:0] wem);
        m_req[m] = 1'b1;
        m_we[m]  = we;
        m_addr[m*AW +: AW] = a;
        m_data[m*DW +: DW] = d;
        m_wem[m*MW +: MW]  = wem;
    endtask

    task automatic set_sdata(input int s, input logic [DW-1:0] d);
        s_data[s*DW +: DW] = d;
    endtask

    task automatic push_exp(input int m, input logic err, input logic [DW-1:0] d);
        exp_t e;
        e.m = m; e.err = err; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_all();
        m_addr = '0; m_data = '0; m_wem = '0; s_data = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (grant_o !== '0) begin errors++; $display("FAIL rst_grant: got %b want 0", grant_o); end
        checks++; if ({s_req_o, m_addr_ok_o, m_data_ok_o, m_err_o} !== '0) begin errors++;
            $display("FAIL rst_oks: s_req %b addr_ok %b data_ok %b err %b want 0", s_req_o, m_addr_ok_o, m_data_ok_o, m_err_o); end
        checks++; if (m_data_o !== '0) begin errors++; $display("FAIL rst_data: got %h want 0", m_data_o); end
        checks++; if (hold_flag_o !== 1'b0) begin errors++; $display("FAIL rst_hold: got %b want 0", hold_flag_o); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read_same_cycle();
        @(negedge clk);
        set_sdata(1, 32'hCAFE_F00D);
        set_master(1, 32'h1000_0010, 1'b0, '0, '0);
        push_exp(1, 1'b0, 32'hCAFE_F00D);
        #1;
        checks++; if (grant_o !== 4'b0000 || s_req_o !== '0) begin errors++;
            $display("FAIL rd_arb_cycle: grant %b s_req %b want 0/0", grant_o, s_req_o); end
        @(negedge clk);
        checks++; if (grant_o !== 4'b0010) begin errors++; $display("FAIL rd_grant: got %b want 0010", grant_o); end
        s_addr_ok = 8'h02; s_data_ok = 8'h02;
        #1;
        checks++; if (s_req_o !== 8'h02) begin errors++; $display("FAIL rd_sreq: got %h want 02", s_req_o); end
        checks++; if (m_addr_ok_o !== 4'b0010 || m_data_ok_o !== 4'b0010) begin errors++;
            $display("FAIL rd_oks: addr_ok %b data_ok %b want 0010/0010", m_addr_ok_o, m_data_ok_o); end
        checks++; if (m_data_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL rd_data: got %h want cafef00d", m_data_o); end
        @(negedge clk);
        clear_all();
        #1;
        checks++; if (grant_o !== '0 || m_data_ok_o !== '0) begin errors++;
            $display("FAIL rd_idle: grant %b data_ok %b want 0/0", grant_o, m_data_ok_o); end
    endtask

    task automatic test_write_latency();
        @(negedge clk);
        set_sdata(2, 32'h5A5A_0002);
        set_master(0, 32'h2000_0004, 1'b1, 32'h1234_5678, 4'hF);
        push_exp(0, 1'b0, 32'h5A5A_0002);
        @(negedge clk);
        checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL wr_grant: got %b want 0001", grant_o); end
        s_addr_ok = 8'h04;
        #1;
        checks++; if (s_req_o !== 8'h04 || s_we_o !== 1'b1) begin errors++;
            $display("FAIL wr_sreq: s_req %h we %b want 04/1", s_req_o, s_we_o); end
        checks++; if (s_addr_o !== 32'h2000_0004 || s_data_o !== 32'h1234_5678 || s_wem_o !== 4'hF) begin errors++;
            $display("FAIL wr_payload: addr %h data %h wem %h", s_addr_o, s_data_o, s_wem_o); end
        checks++; if (m_addr_ok_o !== 4'b0001 || m_data_ok_o !== '0) begin errors++;
            $display("FAIL wr_addr_ok: addr_ok %b data_ok %b want 0001/0000", m_addr_ok_o, m_data_ok_o); end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) begin m_req[0] = 1'b0; s_addr_ok = '0; end
            if (k == 3) s_data_ok = 8'h04;
            #1;
            checks++; if (s_req_o !== '0) begin errors++; $display("FAIL wr_sreq_drop%0d: got %h want 0", k, s_req_o); end
            checks++; if (m_data_ok_o !== ((k == 3) ? 4'b0001 : 4'b0000)) begin errors++;
                $display("FAIL wr_data_ok%0d: got %b want %b", k, m_data_ok_o, (k == 3) ? 4'b0001 : 4'b0000); end
        end
        @(negedge clk);
        clear_all();
        #1;
        checks++; if (grant_o !== '0) begin errors++; $display("FAIL wr_idle: got %b want 0", grant_o); end
    endtask

    task automatic test_decode_err();
        @(negedge clk);
        for (int s = 0; s < int'(NUM_S); s++) set_sdata(s, 32'hFFFF_0000 | 32'(s));
        set_master(2, 32'h9000_0000, 1'b0, '0, '0);
        push_exp(2, 1'b1, 32'h0);
        #1;
        checks++; if (hold_flag_o !== 1'b0) begin errors++; $display("FAIL err_hold_idle: got %b want 0", hold_flag_o); end
        @(negedge clk);
        checks++; if (grant_o !== 4'b0100 || hold_flag_o !== 1'b1) begin errors++;
            $display("FAIL err_grant: grant %b hold %b want 0100/1", grant_o, hold_flag_o); end
        #1;
        checks++; if (m_addr_ok_o !== 4'b0100 || m_data_ok_o !== 4'b0100 || m_err_o !== 4'b0100) begin errors++;
            $display("FAIL err_pulse: addr_ok %b data_ok %b err %b want 0100", m_addr_ok_o, m_data_ok_o, m_err_o); end
        checks++; if (m_data_o !== '0 || s_req_o !== '0) begin errors++;
            $display("FAIL err_quiet: data %h s_req %h want 0/0", m_data_o, s_req_o); end
        @(negedge clk);
        clear_all();
        #1;
        checks++; if (hold_flag_o !== 1'b0 || m_err_o !== '0 || grant_o !== '0) begin errors++;
            $display("FAIL err_after: hold %b err %b grant %b want 0", hold_flag_o, m_err_o, grant_o); end
    endtask

    task automatic test_timeout();
        int  n;
        bit  done;
        @(negedge clk);
        set_sdata(3, 32'hDEAD_BEEF);
        set_master(3, 32'h3000_0000, 1'b0, '0, '0);
        push_exp(3, 1'b1, 32'h0);
        @(negedge clk);
        s_addr_ok = 8'h08;
        #1;
        checks++; if (m_addr_ok_o !== 4'b1000 || hold_flag_o !== 1'b1 || m_data_ok_o !== '0) begin errors++;
            $display("FAIL to_addr: addr_ok %b hold %b data_ok %b want 1000/1/0", m_addr_ok_o, hold_flag_o, m_data_ok_o); end
        n = 0;
        done = 1'b0;
        while (!done && n < 300) begin
            @(negedge clk);
            if (n == 0) begin m_req[3] = 1'b0; s_addr_ok = '0; end
            n++;
            #1;
            if (m_data_ok_o !== '0) done = 1'b1;
        end
        checks++; if (!done || n != int'(TIMEOUT)) begin errors++;
            $display("FAIL to_latency: done %0b after %0d data cycles want %0d", done, n, TIMEOUT); end
        checks++; if (m_err_o !== 4'b1000) begin errors++; $display("FAIL to_err: got %b want 1000", m_err_o); end
        @(negedge clk);
        s_data_ok = 8'h08;
        #1;
        checks++; if (m_data_ok_o !== '0 || grant_o !== '0) begin errors++;
            $display("FAIL to_late: data_ok %b grant %b want 0/0", m_data_ok_o, grant_o); end
        @(negedge clk);
        clear_all();
    endtask

    task automatic test_arbitration();
        logic [NUM_M-1:0] gseq [4];
        logic [NUM_M-1:0] want [4];
        int ng;
        int n;
        @(negedge clk);
        set_sdata(1, 32'h1111_0001);
        set_sdata(2, 32'h2222_0002);
        for (int k = 0; k < 4; k++) begin
`ifdef BUS_RR_ARB_EN
            want[k] = (k % 2 == 1) ? 4'b0010 : 4'b0001;
`else
            want[k] = 4'b0001;
`endif
            gseq[k] = '0;
            if (want[k] == 4'b0001) push_exp(0, 1'b0, 32'h1111_0001);
            else                    push_exp(1, 1'b0, 32'h2222_0002);
        end
        set_master(0, 32'h1000_0000, 1'b0, '0, '0);
        set_master(1, 32'h2000_0000, 1'b0, '0, '0);
        ng = 0;
        n  = 0;
        while (ng < 4 && n < 40) begin
            @(negedge clk);
            s_addr_ok = '0; s_data_ok = '0;
            n++;
            #1;
            if (s_req_o !== '0) begin
                s_addr_ok = s_req_o; s_data_ok = s_req_o;
                gseq[ng] = grant_o;
                ng++;
            end
        end
        #2;
        clear_all();
        checks++; if (ng != 4) begin errors++; $display("FAIL arb_count: got %0d grants want 4", ng); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (gseq[k] !== want[k]) begin errors++;
                $display("FAIL arb_grant%0d: got %b want %b", k, gseq[k], want[k]); end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_sdata(1, 32'h0BAD_0001);
        set_master(0, 32'h1000_0000, 1'b0, '0, '0);
        @(negedge clk);
        s_addr_ok = 8'h02;
        #1;
        checks++; if (m_addr_ok_o !== 4'b0001) begin errors++; $display("FAIL rm_addr_ok: got %b want 0001", m_addr_ok_o); end
        @(negedge clk);
        m_req[0] = 1'b0; s_addr_ok = '0;
        #1;
        checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL rm_data_grant: got %b want 0001", grant_o); end
        #1;
        rst_n = 1'b0;
        s_data_ok = 8'h02;
        #1;
        checks++; if (grant_o !== '0 || m_addr_ok_o !== '0 || m_data_ok_o !== '0 || m_err_o !== '0 || s_req_o !== '0) begin errors++;
            $display("FAIL rm_async: grant %b addr_ok %b data_ok %b err %b s_req %h want 0",
                     grant_o, m_addr_ok_o, m_data_ok_o, m_err_o, s_req_o); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (m_data_ok_o !== '0 || grant_o !== '0) begin errors++;
            $display("FAIL rm_stale: data_ok %b grant %b want 0/0", m_data_ok_o, grant_o); end
        @(negedge clk);
        clear_all();
        set_master(1, 32'h1000_0020, 1'b0, '0, '0);
        push_exp(1, 1'b0, 32'h0BAD_0001);
        @(negedge clk);
        checks++; if (grant_o !== 4'b0010) begin errors++; $display("FAIL rm_regrant: got %b want 0010", grant_o); end
        s_addr_ok = 8'h02; s_data_ok = 8'h02;
        #1;
        checks++; if (m_data_ok_o !== 4'b0010 || m_data_o !== 32'h0BAD_0001) begin errors++;
            $display("FAIL rm_resp: data_ok %b data %h want 0010/0bad0001", m_data_ok_o, m_data_o); end
        @(negedge clk);
        clear_all();
    endtask

    initial begin
        test_reset();
        test_read_same_cycle();
        test_write_latency();
        test_decode_err();
        test_timeout();
        test_arbitration();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_pending: %0d responses never arrived, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
